// File: rtl/vga_sync_gen_pkg.sv
// vga_sync_gen_pkg: 640x480@60Hz timing constants and window helper shared by the raster blocks
package vga_sync_gen_pkg;
  localparam int VGA_CLK_DIV   = 4;
  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_RETRACE = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_RETRACE = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_H_TOTAL   = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_RETRACE + VGA_H_BACK;
  localparam int VGA_V_TOTAL   = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_RETRACE + VGA_V_BACK;
  localparam int VGA_H_SYNC_START = VGA_H_DISPLAY + VGA_H_FRONT;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_RETRACE - 1;
  localparam int VGA_V_SYNC_START = VGA_V_DISPLAY + VGA_V_FRONT;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_RETRACE - 1;
  function automatic logic in_win(input logic [9:0] v, input logic [9:0] lo, input logic [9:0] hi);
    return v >= lo && v <= hi;
  endfunction
endpackage

// File: rtl/vga_sync_gen_pixel_tick_gen.sv
// pixel_tick_gen: board-clock divider producing a one-clk pixel enable every CLK_DIV clocks
//   clk, reset (async, active-high) -> p_tick (high while div_cnt==CLK_DIV-1)
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
)(
  input  logic clk,
  input  logic reset,
  output logic p_tick
);
  localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [W-1:0] div_cnt;
  assign p_tick = div_cnt == W'(CLK_DIV - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) div_cnt <= '0;
    else div_cnt <= p_tick ? '0 : div_cnt + W'(1);
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator (scan position, video window, syncs, frame pulse)
//   clk, reset (async, active-high)
//   p_tick pixel enable; pixel_x/pixel_y scan position; video_on visible area;
//   hsync/vsync active-low syncs; frame_start one-clk pulse on entry to pixel (0,0)
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int CLK_DIV   = VGA_CLK_DIV,
  parameter int H_DISPLAY = VGA_H_DISPLAY,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_RETRACE = VGA_H_RETRACE,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_DISPLAY = VGA_V_DISPLAY,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_RETRACE = VGA_V_RETRACE,
  parameter int V_BACK    = VGA_V_BACK
)(
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);
  localparam logic [9:0] H_LAST = 10'(H_DISPLAY + H_FRONT + H_RETRACE + H_BACK - 1);
  localparam logic [9:0] V_LAST = 10'(V_DISPLAY + V_FRONT + V_RETRACE + V_BACK - 1);
  localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
  localparam logic [9:0] H_SS   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] H_SE   = 10'(H_DISPLAY + H_FRONT + H_RETRACE - 1);
  localparam logic [9:0] V_SS   = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] V_SE   = 10'(V_DISPLAY + V_FRONT + V_RETRACE - 1);
  logic [9:0] h_cnt, v_cnt, h_next, v_next;
  logic       h_end;
  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk(clk),
    .reset(reset),
    .p_tick(p_tick)
  );
  // Next-count values feed the flag registers so they change on the same edge as the counts.
  always_comb begin
    h_end  = h_cnt == H_LAST;
    h_next = !p_tick ? h_cnt : h_end ? '0 : h_cnt + 10'd1;
    v_next = !(p_tick && h_end) ? v_cnt : v_cnt == V_LAST ? '0 : v_cnt + 10'd1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      h_cnt       <= H_LAST;
      v_cnt       <= V_LAST;
      video_on    <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      h_cnt       <= h_next;
      v_cnt       <= v_next;
      video_on    <= h_next < H_VIS && v_next < V_VIS;
      hsync       <= !in_win(h_next, H_SS, H_SE);
      vsync       <= !in_win(v_next, V_SS, V_SE);
      frame_start <= p_tick && h_next == '0 && v_next == '0;
    end
  assign pixel_x = h_cnt;
  assign pixel_y = v_cnt;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed vector table plus scan sequences for the VGA raster generator
module tb_vga_sync_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic       a_tick, a_vid, a_hs, a_vs, a_fs;
  logic [9:0] a_x, a_y;
  logic       b_tick, b_vid, b_hs, b_vs, b_fs;
  logic [9:0] b_x, b_y;
  vga_sync_gen dut_a (
    .clk(clk), .reset(reset), .p_tick(a_tick), .pixel_x(a_x), .pixel_y(a_y),
    .video_on(a_vid), .hsync(a_hs), .vsync(a_vs), .frame_start(a_fs)
  );
  // Shrunk raster with CLK_DIV=1: 15 px per line, 8 lines, 120 clks per frame.
  vga_sync_gen #(
    .CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_RETRACE(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_RETRACE(2), .V_BACK(1)
  ) dut_b (
    .clk(clk), .reset(reset), .p_tick(b_tick), .pixel_x(b_x), .pixel_y(b_y),
    .video_on(b_vid), .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs)
  );
  typedef struct {
    int n; int tick; int x; int y; int vid; int hs; int vs; int fs;
  } vec_t;
  localparam int NV = 16;
  vec_t tv[NV];
  int checks = 0;
  int failures = 0;
  int cyc;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask
  task automatic run_table(input string tag);
    for (int i = 0; i < NV; i++) begin
      repeat (tv[i].n - cyc) @(negedge clk);
      cyc = tv[i].n;
      chk($sformatf("%s_c%0d_tick", tag, cyc), int'(a_tick), tv[i].tick);
      chk($sformatf("%s_c%0d_x", tag, cyc), int'(a_x), tv[i].x);
      chk($sformatf("%s_c%0d_y", tag, cyc), int'(a_y), tv[i].y);
      chk($sformatf("%s_c%0d_video", tag, cyc), int'(a_vid), tv[i].vid);
      chk($sformatf("%s_c%0d_hsync", tag, cyc), int'(a_hs), tv[i].hs);
      chk($sformatf("%s_c%0d_vsync", tag, cyc), int'(a_vs), tv[i].vs);
      chk($sformatf("%s_c%0d_fstart", tag, cyc), int'(a_fs), tv[i].fs);
    end
  endtask
  initial begin
    int hs_low, ticks, errs, max_x, px, py, pt, ex, ey;
    int fs_cnt, vs_low, b_hs_low, last_fs, max_by, tick_low;
    //            n    tick x    y    vid hs vs fs
    tv[0]  = '{0,    0, 799, 524, 0, 1, 1, 0};
    tv[1]  = '{2,    0, 799, 524, 0, 1, 1, 0};
    tv[2]  = '{3,    1, 799, 524, 0, 1, 1, 0};
    tv[3]  = '{4,    0, 0,   0,   1, 1, 1, 1};
    tv[4]  = '{5,    0, 0,   0,   1, 1, 1, 0};
    tv[5]  = '{7,    1, 0,   0,   1, 1, 1, 0};
    tv[6]  = '{8,    0, 1,   0,   1, 1, 1, 0};
    tv[7]  = '{2560, 0, 639, 0,   1, 1, 1, 0};
    tv[8]  = '{2564, 0, 640, 0,   0, 1, 1, 0};
    tv[9]  = '{2624, 0, 655, 0,   0, 1, 1, 0};
    tv[10] = '{2628, 0, 656, 0,   0, 0, 1, 0};
    tv[11] = '{2631, 1, 656, 0,   0, 0, 1, 0};
    tv[12] = '{3008, 0, 751, 0,   0, 0, 1, 0};
    tv[13] = '{3012, 0, 752, 0,   0, 1, 1, 0};
    tv[14] = '{3203, 1, 799, 0,   0, 1, 1, 0};
    tv[15] = '{3204, 0, 0,   1,   1, 1, 1, 0};
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    chk("b_boot_tick", int'(b_tick), 1);
    chk("b_boot_x", int'(b_x), 14);
    chk("b_boot_y", int'(b_y), 7);
    run_table("boot");
    // One full line on the default raster, checked clock by clock against a counter model.
    hs_low = 0; ticks = 0; errs = 0; max_x = 0;
    for (int i = 0; i < 3200; i++) begin
      px = a_x; py = a_y; pt = a_tick;
      @(negedge clk);
      ex = pt ? (px == 799 ? 0 : px + 1) : px;
      ey = (pt && px == 799) ? (py == 524 ? 0 : py + 1) : py;
      if (a_x != 10'(ex) || a_y != 10'(ey)) errs++;
      if (a_hs != !(a_x >= 656 && a_x <= 751)) errs++;
      if (a_vid != (a_x < 640 && a_y < 480)) errs++;
      if (a_vs != 1'b1 || a_fs != 1'b0) errs++;
      if (a_tick) ticks++;
      if (!a_hs) hs_low++;
      if (int'(a_x) > max_x) max_x = a_x;
    end
    cyc += 3200;
    chk("line_model_errs", errs, 0);
    chk("line_hsync_low_clks", hs_low, 384);
    chk("line_ticks", ticks, 800);
    chk("line_max_x", max_x, 799);
    chk("line_end_x", int'(a_x), 0);
    chk("line_end_y", int'(a_y), 2);
    // Mid-line reset: outputs must return to reset values without a clock edge.
    repeat (1200) @(negedge clk);
    chk("mid_x_before", int'(a_x), 300);
    chk("mid_y_before", int'(a_y), 2);
    #2 reset = 1'b1;
    #1;
    chk("async_x", int'(a_x), 799);
    chk("async_y", int'(a_y), 524);
    chk("async_video", int'(a_vid), 0);
    chk("async_hsync", int'(a_hs), 1);
    chk("async_vsync", int'(a_vs), 1);
    chk("async_tick", int'(a_tick), 0);
    chk("async_b_x", int'(b_x), 14);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    run_table("rst");
    // Full frames on the shrunk raster: period, sync windows, video window, counter model.
    fs_cnt = 0; vs_low = 0; b_hs_low = 0; last_fs = -1; errs = 0; max_x = 0; max_by = 0; tick_low = 0;
    for (int i = 0; i < 360; i++) begin
      px = b_x; py = b_y;
      @(negedge clk);
      ex = px == 14 ? 0 : px + 1;
      ey = px == 14 ? (py == 7 ? 0 : py + 1) : py;
      if (b_x != 10'(ex) || b_y != 10'(ey)) errs++;
      if (b_hs != !(b_x >= 10 && b_x <= 12)) errs++;
      if (b_vs != !(b_y >= 5 && b_y <= 6)) errs++;
      if (b_vid != (b_x < 8 && b_y < 4)) errs++;
      if (b_fs != (b_x == 0 && b_y == 0)) errs++;
      if (!b_tick) tick_low++;
      if (!b_vs) vs_low++;
      if (!b_hs) b_hs_low++;
      if (int'(b_x) > max_x) max_x = b_x;
      if (int'(b_y) > max_by) max_by = b_y;
      if (b_fs) begin
        if (last_fs >= 0) chk($sformatf("frame_period_at_%0d", i), i - last_fs, 120);
        last_fs = i;
        fs_cnt++;
      end
    end
    chk("frame_model_errs", errs, 0);
    chk("frame_tick_low_clks", tick_low, 0);
    chk("frame_starts", fs_cnt, 3);
    chk("frame_vsync_low_clks", vs_low, 90);
    chk("frame_hsync_low_clks", b_hs_low, 72);
    chk("frame_max_x", max_x, 14);
    chk("frame_max_y", max_by, 7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
